// File: rtl/smc_state_param_if.sv
// Bus bundle between the AHB-side access decoder and the static memory
// controller state machine: pending-access request, timing config and strobes.
interface smc_state_param_if #(
    parameter int NCS  = 4,
    parameter int WS_W = 8,
    parameter int LE_W = 2,
    parameter int TE_W = 2,
    parameter int TA_W = 2
);
    logic            new_access;
    logic            n_read;
    logic [NCS-1:0]  cs;
    logic            mac_done;
    logic [LE_W-1:0] csle_cfg;
    logic [WS_W-1:0] ws_cfg;
    logic [TE_W-1:0] cste_cfg;
    logic [TA_W-1:0] ta_cfg;
    logic [2:0]      smc_state;
    logic            valid_access;
    logic            smc_done;
    logic            smc_idle;
    logic            latch_data;
    logic [NCS-1:0]  n_cs_out;
    logic            n_oe;
    logic            n_we;

    modport master (
        output new_access, n_read, cs, mac_done, csle_cfg, ws_cfg, cste_cfg, ta_cfg,
        input  smc_state, valid_access, smc_done, smc_idle, latch_data, n_cs_out, n_oe, n_we
    );

    modport slave (
        input  new_access, n_read, cs, mac_done, csle_cfg, ws_cfg, cste_cfg, ta_cfg,
        output smc_state, valid_access, smc_done, smc_idle, latch_data, n_cs_out, n_oe, n_we
    );
endinterface

// File: rtl/smc_state_param.sv
// Static memory controller access sequencer: STORE / CS leading edge / read-write
// wait states / CS float / bus turnaround, with registered chip-select and strobes.
module smc_state_param #(
    parameter int NCS  = 4,
    parameter int WS_W = 8,
    parameter int LE_W = 2,
    parameter int TE_W = 2,
    parameter int TA_W = 2
) (
    input  logic             sys_clk,
    input  logic             n_sys_reset,
    smc_state_param_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STORE = 3'd1,
        ST_LE    = 3'd2,
        ST_RW    = 3'd3,
        ST_FLOAT = 3'd4,
        ST_TURN  = 3'd5
    } state_t;

    state_t          state_q, state_d, accept_st_s, succ_st_s;
    logic [NCS-1:0]  cs_q, cs_d, n_cs_q, n_cs_d;
    logic            n_read_q, n_read_d, n_oe_q, n_oe_d, n_we_q, n_we_d;
    logic [LE_W-1:0] csle_q, csle_d, le_cnt_q, le_cnt_d;
    logic [WS_W-1:0] ws_q, ws_d, ws_cnt_q, ws_cnt_d;
    logic [TE_W-1:0] cste_q, cste_d, te_cnt_q, te_cnt_d;
    logic [TA_W-1:0] ta_cnt_q, ta_cnt_d;
    logic            eoa_s, valid_s, change_s, cs_on_s;

    // End-of-access decode, acceptance, and the state that follows an access
    always_comb begin
        eoa_s = 1'b0;
        case (state_q)
            ST_RW:    eoa_s = (ws_cnt_q == '0) && (cste_q == '0);
            ST_FLOAT: eoa_s = (te_cnt_q <= TE_W'(1));
            default:  eoa_s = 1'b0;
        endcase
        // Gated by reset so acceptance is never reported while the block is held
        valid_s     = n_sys_reset && bus.new_access &&
                      ((state_q == ST_IDLE) || (eoa_s && bus.mac_done));
        change_s    = (bus.cs != cs_q) || (bus.n_read != n_read_q);
        accept_st_s = (change_s && (bus.ta_cfg != '0)) ? ST_TURN : ST_STORE;
        if (!bus.mac_done) begin
            succ_st_s = (csle_q != '0) ? ST_LE : ST_RW;
        end else if (valid_s) begin
            succ_st_s = accept_st_s;
        end else begin
            succ_st_s = ST_IDLE;
        end
    end

    // Next-state, access registration and phase counters
    always_comb begin
        state_d  = state_q;
        cs_d     = valid_s ? bus.cs       : cs_q;
        n_read_d = valid_s ? bus.n_read   : n_read_q;
        csle_d   = valid_s ? bus.csle_cfg : csle_q;
        ws_d     = valid_s ? bus.ws_cfg   : ws_q;
        cste_d   = valid_s ? bus.cste_cfg : cste_q;
        ta_cnt_d = valid_s ? bus.ta_cfg   : ta_cnt_q;
        le_cnt_d = le_cnt_q;
        ws_cnt_d = ws_cnt_q;
        te_cnt_d = te_cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = valid_s ? accept_st_s : ST_IDLE;
            end
            ST_STORE: begin
                le_cnt_d = csle_q;
                ws_cnt_d = ws_q;
                state_d  = (csle_q != '0) ? ST_LE : ST_RW;
            end
            ST_LE: begin
                le_cnt_d = (le_cnt_q != '0) ? le_cnt_q - LE_W'(1) : '0;
                state_d  = (le_cnt_q <= LE_W'(1)) ? ST_RW : ST_LE;
            end
            ST_RW: begin
                if (ws_cnt_q != '0) begin
                    ws_cnt_d = ws_cnt_q - WS_W'(1);
                end else if (cste_q != '0) begin
                    te_cnt_d = cste_q;
                    state_d  = ST_FLOAT;
                end else begin
                    // Reload covers the next beat of a multiple access
                    le_cnt_d = csle_q;
                    ws_cnt_d = ws_q;
                    state_d  = succ_st_s;
                end
            end
            ST_FLOAT: begin
                te_cnt_d = (te_cnt_q != '0) ? te_cnt_q - TE_W'(1) : '0;
                if (eoa_s) begin
                    le_cnt_d = csle_q;
                    ws_cnt_d = ws_q;
                    state_d  = succ_st_s;
                end else begin
                    state_d  = ST_FLOAT;
                end
            end
            ST_TURN: begin
                ta_cnt_d = (ta_cnt_q != '0) ? ta_cnt_q - TA_W'(1) : '0;
                state_d  = (ta_cnt_q <= TA_W'(1)) ? ST_STORE : ST_TURN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with it
    always_comb begin
        cs_on_s = (state_d == ST_LE) || (state_d == ST_RW) || (state_d == ST_FLOAT) ||
                  ((state_d == ST_STORE) && eoa_s);
        n_cs_d  = cs_on_s ? ~cs_d : '1;
        n_oe_d  = !((state_d == ST_RW) && !n_read_d);
        n_we_d  = !((state_d == ST_RW) && n_read_d);
    end

    // State, configuration, counter and strobe registers
    always_ff @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            state_q  <= ST_IDLE;
            cs_q     <= '0;
            n_read_q <= 1'b0;
            csle_q   <= '0;
            ws_q     <= '0;
            cste_q   <= '0;
            le_cnt_q <= '0;
            ws_cnt_q <= '0;
            te_cnt_q <= '0;
            ta_cnt_q <= '0;
            n_cs_q   <= '1;
            n_oe_q   <= 1'b1;
            n_we_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            n_read_q <= n_read_d;
            csle_q   <= csle_d;
            ws_q     <= ws_d;
            cste_q   <= cste_d;
            le_cnt_q <= le_cnt_d;
            ws_cnt_q <= ws_cnt_d;
            te_cnt_q <= te_cnt_d;
            ta_cnt_q <= ta_cnt_d;
            n_cs_q   <= n_cs_d;
            n_oe_q   <= n_oe_d;
            n_we_q   <= n_we_d;
        end
    end

    assign bus.smc_state    = state_q;
    assign bus.valid_access = valid_s;
    assign bus.smc_done     = eoa_s;
    assign bus.smc_idle     = (state_d == ST_IDLE);
    assign bus.latch_data   = (state_q == ST_RW) && (ws_cnt_q == '0) && !n_read_q;
    assign bus.n_cs_out     = n_cs_q;
    assign bus.n_oe         = n_oe_q;
    assign bus.n_we         = n_we_q;

endmodule

// File: tb/tb_smc_state_param.sv
// Bench for smc_state_param: directed access scenarios plus random traffic, all
// checked cycle by cycle against a per-access phase-list reference model.
module tb_smc_state_param;
    localparam int NCS  = 4;
    localparam int WS_W = 8;
    localparam int LE_W = 2;
    localparam int TE_W = 2;
    localparam int TA_W = 2;

    logic sys_clk = 1'b0;
    logic n_sys_reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    smc_state_param_if #(.NCS(NCS), .WS_W(WS_W), .LE_W(LE_W), .TE_W(TE_W), .TA_W(TA_W)) bus_if ();

    smc_state_param #(.NCS(NCS), .WS_W(WS_W), .LE_W(LE_W), .TE_W(TE_W), .TA_W(TA_W)) dut (
        .sys_clk     (sys_clk),
        .n_sys_reset (n_sys_reset),
        .bus         (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    // One expected cycle of the reference model
    typedef struct packed {
        logic [2:0]     st;
        logic [NCS-1:0] ncs;
        logic           noe;
        logic           nwe;
        logic           latch;
        logic           eoa;
    } cyc_t;

    cyc_t           plan[$];
    logic [NCS-1:0] m_cs;
    logic           m_nr;
    int             m_le, m_ws, m_te;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_cyc(input logic [2:0] st, input logic [NCS-1:0] ncs,
                            input logic noe, input logic nwe, input logic latch, input logic eoa);
        cyc_t c;
        c.st = st; c.ncs = ncs; c.noe = noe; c.nwe = nwe; c.latch = latch; c.eoa = eoa;
        plan.push_back(c);
    endtask

    // One beat: LE phase, RW phase (ws+1 cycles), FLOAT phase
    task automatic push_beat();
        for (int i = 0; i < m_le; i++) push_cyc(3'd2, ~m_cs, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= m_ws; i++)
            push_cyc(3'd3, ~m_cs, m_nr, !m_nr, (i == m_ws) && !m_nr, (i == m_ws) && (m_te == 0));
        for (int i = 0; i < m_te; i++) push_cyc(3'd4, ~m_cs, 1'b1, 1'b1, 1'b0, i == m_te - 1);
    endtask

    task automatic model_reset();
        plan.delete();
        m_cs = '0; m_nr = 1'b0; m_le = 0; m_ws = 0; m_te = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(bus_if.smc_state), 32'd0);
        chk({tag, "_ncs"},   32'(bus_if.n_cs_out), 32'hF);
        chk({tag, "_noe"},   32'(bus_if.n_oe), 32'd1);
        chk({tag, "_nwe"},   32'(bus_if.n_we), 32'd1);
        chk({tag, "_done"},  32'(bus_if.smc_done), 32'd0);
        chk({tag, "_latch"}, 32'(bus_if.latch_data), 32'd0);
        chk({tag, "_valid"}, 32'(bus_if.valid_access), 32'd0);
        chk({tag, "_idle"},  32'(bus_if.smc_idle), 32'd1);
    endtask

    // Drive one cycle of inputs, compare against the model, then advance it
    task automatic run_cycle(input logic na, input logic nr, input logic [NCS-1:0] c,
                             input logic mac, input int le, input int ws, input int te, input int ta);
        cyc_t cur;
        logic at_eoa, exp_valid, turn;
        @(negedge sys_clk);
        bus_if.new_access = na;  bus_if.n_read = nr;  bus_if.cs = c;  bus_if.mac_done = mac;
        bus_if.csle_cfg = LE_W'(le);  bus_if.ws_cfg = WS_W'(ws);
        bus_if.cste_cfg = TE_W'(te);  bus_if.ta_cfg = TA_W'(ta);
        #1;
        if (plan.size() != 0) cur = plan[0];
        else begin
            cur.st = 3'd0; cur.ncs = '1; cur.noe = 1'b1; cur.nwe = 1'b1; cur.latch = 1'b0; cur.eoa = 1'b0;
        end
        at_eoa    = (plan.size() != 0) && cur.eoa;
        exp_valid = na && ((plan.size() == 0) || (at_eoa && mac));
        chk("state", 32'(bus_if.smc_state), 32'(cur.st));
        chk("n_cs",  32'(bus_if.n_cs_out), 32'(cur.ncs));
        chk("n_oe",  32'(bus_if.n_oe), 32'(cur.noe));
        chk("n_we",  32'(bus_if.n_we), 32'(cur.nwe));
        chk("latch", 32'(bus_if.latch_data), 32'(cur.latch));
        chk("done",  32'(bus_if.smc_done), 32'(cur.eoa));
        chk("valid", 32'(bus_if.valid_access), 32'(exp_valid));
        if (plan.size() != 0) void'(plan.pop_front());
        if (at_eoa && !mac) begin
            push_beat();
        end else if (exp_valid) begin
            turn = ((c != m_cs) || (nr != m_nr)) && (ta != 0);
            m_cs = c; m_nr = nr; m_le = le; m_ws = ws; m_te = te;
            for (int i = 0; i < (turn ? ta : 0); i++) push_cyc(3'd5, '1, 1'b1, 1'b1, 1'b0, 1'b0);
            push_cyc(3'd1, (at_eoa && !turn) ? ~c : '1, 1'b1, 1'b1, 1'b0, 1'b0);
            push_beat();
        end
        chk("idle", 32'(bus_if.smc_idle), 32'(plan.size() == 0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, 1'b1, 0, 0, 0, 0);
    endtask

    initial begin
        logic           r_na, r_nr, r_mac;
        logic [NCS-1:0] r_cs;
        bus_if.new_access = 1'b0; bus_if.n_read = 1'b0; bus_if.cs = '0; bus_if.mac_done = 1'b1;
        bus_if.csle_cfg = '0; bus_if.ws_cfg = '0; bus_if.cste_cfg = '0; bus_if.ta_cfg = '0;
        n_sys_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        bus_if.new_access = 1'b1;
        #1;
        check_reset_values("rst");
        bus_if.new_access = 1'b0;
        @(negedge sys_clk);
        n_sys_reset = 1'b1;

        // Read with leading edge, wait states and float
        run_cycle(1'b1, 1'b0, 4'b0001, 1'b1, 2, 3, 1, 0);
        idle_cycles(10);
        // Zero-timing write
        run_cycle(1'b1, 1'b1, 4'b0001, 1'b1, 0, 0, 0, 0);
        idle_cycles(3);
        // Back-to-back reads with new_access held
        for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 4'b0001, 1'b1, 1, 1, 0, 0);
        idle_cycles(4);
        // Read CS0 then write CS1 with turnaround
        run_cycle(1'b1, 1'b0, 4'b0001, 1'b1, 0, 1, 0, 2);
        for (int i = 0; i < 9; i++) run_cycle(1'b1, 1'b1, 4'b0010, 1'b1, 0, 1, 0, 2);
        idle_cycles(6);
        // Multiple access: two beats with mac_done low
        run_cycle(1'b1, 1'b0, 4'b0010, 1'b0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, '0, 1'b0, 0, 0, 0, 0);
        idle_cycles(4);
        // Reset asserted in the middle of the wait states
        run_cycle(1'b1, 1'b0, 4'b0100, 1'b1, 0, 5, 0, 0);
        idle_cycles(1);
        @(negedge sys_clk);
        chk("mid_rw_state", 32'(bus_if.smc_state), 32'd3);
        #2;
        n_sys_reset = 1'b0;
        bus_if.new_access = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge sys_clk);
        bus_if.new_access = 1'b0;
        n_sys_reset = 1'b1;
        idle_cycles(3);

        // Random traffic over two favoured chip selects
        for (int n = 0; n < 3000; n++) begin
            r_na  = ($urandom_range(0, 2) != 0);
            r_nr  = 1'($urandom_range(0, 1));
            r_mac = ($urandom_range(0, 3) != 0);
            r_cs  = NCS'(1) << ($urandom_range(0, 3) == 0 ? $urandom_range(0, NCS - 1) : $urandom_range(0, 1));
            run_cycle(r_na, r_nr, r_cs, r_mac, $urandom_range(0, 3), $urandom_range(0, 6),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
        idle_cycles(40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/smc_state_param.md
SMC_STATE_PARAM -- requirements
Module: smc_state_param

Interface
REQ-001 Parameter NCS, default 4: number of chip selects.
REQ-002 Parameter WS_W, default 8: width of the wait-state count.
REQ-003 Parameter LE_W, default 2: width of the CS leading-edge count.
REQ-004 Parameter TE_W, default 2: width of the CS trailing-edge (float) count.
REQ-005 Parameter TA_W, default 2: width of the bus-turnaround count.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 sys_clk  in  1  system clock; all state changes on the rising edge.
REQ-008 n_sys_reset  in  1  asynchronous active-low reset.
REQ-009 new_access  in  1  new valid AHB access pending.
REQ-010 n_read  in  1  direction of the pending access: 0 = read, 1 = write.
REQ-011 cs  in  NCS  one-hot chip select of the pending access.
REQ-012 mac_done  in  1  high on the last beat of a multiple access.
REQ-013 csle_cfg  in  LE_W  leading-edge cycles for the pending access.
REQ-014 ws_cfg  in  WS_W  wait states for the pending access.
REQ-015 cste_cfg  in  TE_W  trailing-edge float cycles for the pending access.
REQ-016 ta_cfg  in  TA_W  turnaround cycles inserted on a direction or CS change.
REQ-017 smc_state  out  3  current state: IDLE=0, STORE=1, LE=2, RW=3, FLOAT=4, TURN=5.
REQ-018 valid_access  out  1  pending access accepted this cycle.
REQ-019 smc_done  out  1  last cycle of an access.
REQ-020 smc_idle  out  1  next state is IDLE.
REQ-021 latch_data  out  1  read data must be captured this cycle.
REQ-022 n_cs_out  out  NCS  active-low chip selects.
REQ-023 n_oe  out  1  active-low output enable.
REQ-024 n_we  out  1  active-low write enable.

Function
REQ-025 valid_access is combinational: new_access AND (state==IDLE OR end-of-access cycle with mac_done=1); when high, the block shall register cs, n_read, csle_cfg, ws_cfg, cste_cfg, ta_cfg.
REQ-026 IDLE: on valid_access, go to STORE, or to TURN when ta_cfg!=0 and (cs or n_read differs from the last registered access); otherwise stay in IDLE.
REQ-027 STORE lasts 1 cycle, loads le_cnt=csle and ws_cnt=ws, then goes to LE if csle!=0, else to RW.
REQ-028 LE lasts exactly csle cycles (le_cnt decrements), then goes to RW.
REQ-029 RW lasts ws+1 cycles (ws_cnt decrements to 0); when ws_cnt==0 the FSM goes to FLOAT with te_cnt=cste if cste!=0, else that cycle is end-of-access.
REQ-030 FLOAT lasts cste cycles; its last cycle is end-of-access.
REQ-031 Successor of end-of-access, in priority order:
- mac_done=0: go to LE (csle!=0) or RW, reloading counters from the registered cfg.
- valid_access with same cs and same n_read: go to STORE.
- valid_access with a cs or direction change: go to TURN (ta_cfg!=0) or STORE.
- otherwise: go to IDLE.
REQ-032 TURN lasts ta cycles with all CS, n_oe and n_we deasserted, then goes to STORE; new_access is ignored during TURN.
REQ-033 smc_done=1 exactly on end-of-access cycles; smc_idle=1 when the next state is IDLE.
REQ-034 latch_data=1 on the last RW cycle of a registered read (ws_cnt==0).
REQ-035 n_cs_out[i]=0 for the registered CS in LE, RW and FLOAT, and in STORE when entered directly from end-of-access (back-to-back CS held); otherwise all ones.
REQ-036 n_oe=0 in RW for reads and n_we=0 in RW for writes; both are registered outputs, deasserted in all other states.
REQ-037 Counters saturate at 0 and never wrap; all-zero cfg gives the access STORE then RW (1 cycle), with that RW cycle the end-of-access.
REQ-038 Encodings 6-7 are illegal and shall recover to IDLE on the next clock.

Reset
REQ-039 On n_sys_reset=0, asynchronously and including mid-access: state=IDLE, all counters and registered cfg=0, n_cs_out all ones, n_oe=n_we=1, smc_done=latch_data=valid_access=0, smc_idle=1.

Verification
REQ-040 Read, csle=2, ws=3, cste=1, mac_done=1: STORE, LE x2, RW x4, FLOAT x1, IDLE; latch_data on the 4th RW cycle; smc_done on the FLOAT cycle.
REQ-041 All cfg=0, write: STORE, RW x1, IDLE; n_we low for 1 cycle; smc_done and smc_idle in the RW cycle.
REQ-042 Back-to-back reads, same CS, new_access held: n_cs_out held low continuously through the STORE between accesses.
REQ-043 Read to CS0 then write to CS1, ta_cfg=2: end-of-access, TURN x2 with all CS high, then STORE.
REQ-044 mac_done=0 for 2 beats, csle=1: LE re-entered each beat with no STORE; smc_done on each beat.
REQ-045 Reset asserted in RW with ws_cnt=5: outputs reach reset values immediately; IDLE after release.
